uart_rx_ex: RTL and testbench
=============================

# uart_rx_ex

Parametrised UART receiver, the next generation of the 8N1-only receiver. It adds configurable payload width, optional odd/even parity, 1 or 2 stop bits, 3-sample majority voting, false-start rejection and per-word error flags. Received words go into a first-word-fall-through FIFO with a valid/ready output handshake. The block sits between the external RX pin and the APB peripheral register file.

## Interface
Parameters:
- `CLK_HZ`, 10_000_000, system clock frequency in Hz.
- `BIT_RATE`, 115200, line bit rate in bit/s.
- `PAYLOAD_BITS`, 8, data bits per frame; legal range 5..9.
- `PARITY_MODE`, 0, parity setting: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1, stop bits per frame; legal values 1 or 2.
- `FIFO_DEPTH`, 4, receive FIFO depth in words; power of 2, at least 2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous active-high reset.
- `uart_rxd`  in  1  asynchronous serial input; idles high.
- `rx_data`  out  PAYLOAD_BITS  head-of-FIFO data; 0 whenever `rx_valid`=0.
- `rx_parity_err`  out  1  head word had a parity mismatch; 0 whenever `rx_valid`=0.
- `rx_frame_err`  out  1  head word had a stop bit sampled 0; 0 whenever `rx_valid`=0.
- `rx_valid`  out  1  FIFO not empty.
- `rx_ready`  in  1  consumer accepts the head word.
- `rx_overrun`  out  1  one-cycle pulse when a completed word is dropped because the FIFO is full.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of words held.
- `busy`  out  1  FSM is not in IDLE.

## Operation
- Derived constants: CYCLES_PER_BIT = CLK_HZ/BIT_RATE (integer division); H = CYCLES_PER_BIT/2.
- Input path: 2-flop synchroniser reset to 2'b11; a third registered copy holds the previous synchronised value for edge detection.
- Sampling: a bit-cycle counter runs 0..CYCLES_PER_BIT-1 in every non-IDLE state. The line is sampled at counts H-1, H and H+1, and the bit value is the 2-of-3 majority.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: waits for a synchronised falling edge (previous 1, current 0), then goes to START with the counter at 0. A line already low does not start a frame.
  - START: if the majority is 1, it is a false start; return to IDLE at count H+1 and push nothing. Otherwise go to DATA at count CYCLES_PER_BIT-1.
  - DATA: PAYLOAD_BITS bits, LSB first, shifted into the data register. After the last bit, go to PARITY if PARITY_MODE≠0, else to STOP.
  - PARITY: parity error = (XOR of data bits XOR parity bit) ≠ (PARITY_MODE==1). Odd parity passes when the total number of ones is odd.
  - STOP: STOP_BITS bits. The frame error is set if any stop bit majority is 0. At count H+1 of the final stop bit, push {parity_err, frame_err, data} and go to IDLE. Ending at mid-bit allows resync on a back-to-back start.
- FIFO:
  - Pop when `rx_valid` && `rx_ready`.
  - Push while full with no pop: word dropped, `rx_overrun` pulses for one cycle, contents unchanged.
  - Push while full with a pop in the same cycle: accepted, `fifo_level` unchanged, no overrun.
  - Pop while empty: no effect.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Reset (any time, including mid-frame): FSM to IDLE, counters cleared, FIFO emptied, partial frame discarded. All outputs go to 0 (`rx_data`, both error flags, `rx_valid`, `rx_overrun`, `fifo_level`, `busy`).

## Timing
- `uart_rxd` to synchronised value: 2 cycles. The falling edge is recognised one cycle later, when `busy` rises.
- Push occurs at count H+1 of the final stop bit. `rx_valid`, `rx_data` and the error flags update on the next clock edge. `fifo_level` updates on the same edge.
- Pop: the head advances on the edge after `rx_valid`&&`rx_ready`. Back-to-back pops at one word per cycle are supported.
- `rx_overrun` is high for exactly the cycle after the dropped push.
- `busy` falls on the same edge as the push, or as the false-start abort.

## Test plan
All scenarios use the defaults unless stated: CYCLES_PER_BIT=86, H=43.
- 8N1 frame 0xA5, `rx_ready`=0 -> `rx_valid`=1, `rx_data`=0xA5, both error flags 0, `fifo_level`=1. Pulse `rx_ready` for 1 cycle -> `rx_valid`=0, `rx_data`=0.
- PARITY_MODE=2: send 0x03 with parity bit 1 -> `rx_data`=0x03, `rx_parity_err`=1. Resend with parity bit 0 -> `rx_parity_err`=0.
- Send 0x55 with stop bit 0, then hold the line low for 20 bit times -> exactly one word (0x55, `rx_frame_err`=1). No further word until the line goes high and a new frame 0x12 arrives, which is received cleanly.
- 20-cycle low glitch on an idle line -> `busy` pulses, then returns to 0; no push; `fifo_level` stays 0.
- FIFO_DEPTH=4, `rx_ready`=0: send 0x01..0x05 back-to-back -> `fifo_level`=4 and a single `rx_overrun` pulse on the 5th word. Draining returns 0x01, 0x02, 0x03, 0x04.
- Assert `reset` for 1 cycle during DATA bit 3 -> `busy`=0, `fifo_level`=0 next cycle. A following frame 0x5A is received with no errors.

Source files
------------

// File: rtl/uart_rx_ex.sv
// UART receiver: configurable payload/parity/stop bits, 3-sample majority voting,
// false-start rejection and a first-word-fall-through receive FIFO.
module uart_rx_ex #(
  parameter int unsigned CLK_HZ       = 10_000_000,
  parameter int unsigned BIT_RATE     = 115200,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          uart_rxd,
  output logic [PAYLOAD_BITS-1:0]       rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);

  localparam int unsigned CPB = CLK_HZ / BIT_RATE;
  localparam int unsigned H   = CPB / 2;
  localparam int unsigned CW  = $clog2(CPB);
  localparam int unsigned BW  = $clog2(PAYLOAD_BITS);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LW  = AW + 1;
  localparam int unsigned EW  = PAYLOAD_BITS + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t                   state_q, state_d;
  logic [1:0]               sync_q;
  logic                     prev_q;
  logic                     rxd_s;
  logic [CW-1:0]            cnt_q;
  logic [BW-1:0]            bit_q;
  logic                     stop_q;
  logic [1:0]               samp_q;
  logic [PAYLOAD_BITS-1:0]  shift_q;
  logic                     perr_q;
  logic                     ferr_q;
  logic                     at_s0, at_s1, at_mid, at_end;
  logic                     maj;
  logic                     push_c;
  logic [EW-1:0]            word_c;

  assign rxd_s  = sync_q[1];
  assign at_s0  = (cnt_q == CW'(H - 1));
  assign at_s1  = (cnt_q == CW'(H));
  assign at_mid = (cnt_q == CW'(H + 1));
  assign at_end = (cnt_q == CW'(CPB - 1));
  assign maj    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s) | (samp_q[1] & rxd_s);
  assign word_c = {perr_q, ferr_q | ~maj, shift_q};

  // Synchroniser plus previous-value copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], uart_rxd};
      prev_q <= sync_q[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    push_c  = 1'b0;
    case (state_q)
      S_IDLE:   if (prev_q && !rxd_s) state_d = S_START;
      S_START: begin
        if (at_mid && maj) state_d = S_IDLE;
        else if (at_end)   state_d = S_DATA;
      end
      S_DATA:
        if (at_end && bit_q == BW'(PAYLOAD_BITS - 1))
          state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (at_end) state_d = S_STOP;
      S_STOP: begin
        // Frame ends at mid stop bit so a back-to-back start edge is not missed.
        if (at_mid && stop_q == 1'(STOP_BITS - 1)) begin
          push_c  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Bit timing, sampling and frame datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      samp_q  <= 2'b00;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      if (state_q == S_IDLE || state_d == S_IDLE || at_end) cnt_q <= '0;
      else                                                  cnt_q <= cnt_q + CW'(1);
      if (at_s0) samp_q[0] <= rxd_s;
      if (at_s1) samp_q[1] <= rxd_s;
      case (state_q)
        S_IDLE: begin
          bit_q  <= '0;
          stop_q <= 1'b0;
          perr_q <= 1'b0;
          ferr_q <= 1'b0;
        end
        S_DATA: begin
          if (at_mid) shift_q <= {maj, shift_q[PAYLOAD_BITS-1:1]};
          if (at_end) bit_q   <= bit_q + BW'(1);
        end
        S_PARITY:
          if (at_mid) perr_q <= ((^shift_q) ^ maj) != (PARITY_MODE == 1);
        S_STOP: begin
          if (at_mid && !maj) ferr_q <= 1'b1;
          if (at_end)         stop_q <= stop_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q;
  logic          ovr_q;
  logic          pop_c, full_c, wr_c;
  logic [EW-1:0] head_c;

  assign rx_valid = (level_q != '0);
  assign full_c   = (level_q == LW'(FIFO_DEPTH));
  assign pop_c    = rx_valid && rx_ready;
  assign wr_c     = push_c && (!full_c || pop_c);
  assign head_c   = mem[rd_q];

  always_ff @(posedge clk) begin
    if (wr_c) mem[wr_q] <= word_c;
  end

  // FIFO pointers, occupancy and overrun pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      if (wr_c)  wr_q <= wr_q + AW'(1);
      if (pop_c) rd_q <= rd_q + AW'(1);
      case ({wr_c, pop_c})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      ovr_q <= push_c && full_c && !pop_c;
    end
  end

  assign rx_data       = rx_valid ? head_c[PAYLOAD_BITS-1:0] : '0;
  assign rx_frame_err  = rx_valid & head_c[PAYLOAD_BITS];
  assign rx_parity_err = rx_valid & head_c[PAYLOAD_BITS+1];
  assign rx_overrun    = ovr_q;
  assign fifo_level    = level_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ex.sv
// Bench for uart_rx_ex: an 8N1 instance and an even-parity instance, checked against
// a queue-based model of received words built from the frame contents sent.
module tb_uart_rx_ex;

  localparam int CPB = 86;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd0, rxd1, ready0, ready1;
  logic [7:0] data0, data1;
  logic       perr0, perr1, ferr0, ferr1, valid0, valid1, ovr0, ovr1, busy0, busy1;
  logic [2:0] level0, level1;

  always #5 clk = ~clk;

  uart_rx_ex u_dut (
    .clk(clk), .reset(reset), .uart_rxd(rxd0), .rx_data(data0),
    .rx_parity_err(perr0), .rx_frame_err(ferr0), .rx_valid(valid0), .rx_ready(ready0),
    .rx_overrun(ovr0), .fifo_level(level0), .busy(busy0)
  );

  uart_rx_ex #(.PARITY_MODE(2)) u_par (
    .clk(clk), .reset(reset), .uart_rxd(rxd1), .rx_data(data1),
    .rx_parity_err(perr1), .rx_frame_err(ferr1), .rx_valid(valid1), .rx_ready(ready1),
    .rx_overrun(ovr1), .fifo_level(level1), .busy(busy1)
  );

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } word_t;

  word_t q0[$];
  word_t q1[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    exp_ovr0 = 0, exp_ovr1 = 0;
  int    ovr_seen0 = 0, ovr_seen1 = 0;
  int    busy_rises = 0;
  logic  busy0_d = 1'b0;

  always @(negedge clk) begin
    if (ovr0 === 1'b1) ovr_seen0++;
    if (ovr1 === 1'b1) ovr_seen1++;
    if (busy0 === 1'b1 && busy0_d !== 1'b1) busy_rises++;
    busy0_d = busy0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input int sel, input logic v, input int cycles);
    if (sel == 0) rxd0 = v;
    else          rxd1 = v;
    repeat (cycles) @(negedge clk);
  endtask

  // Sends one frame and records what the receiver should deliver (pbit < 0: no parity bit).
  task automatic send_frame(input int sel, input logic [7:0] d, input int pbit, input logic stop);
    word_t w;
    int    ones;
    hold(sel, 1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(sel, d[i], CPB);
    if (pbit >= 0) hold(sel, pbit[0], CPB);
    hold(sel, stop, CPB);
    ones   = $countones(d) + ((pbit > 0) ? 1 : 0);
    w.data = d;
    w.perr = (pbit >= 0) && (ones % 2 == 1);
    w.ferr = !stop;
    if (sel == 0) begin
      if (q0.size() < 4) q0.push_back(w);
      else               exp_ovr0++;
    end else begin
      if (q1.size() < 4) q1.push_back(w);
      else               exp_ovr1++;
    end
  endtask

  // Checks level, then pops every queued word with rx_ready held high back-to-back.
  task automatic drain(input int sel, input string tag);
    word_t w;
    check({tag, "_level"}, sel ? level1 : level0, sel ? q1.size() : q0.size());
    while ((sel ? q1.size() : q0.size()) > 0) begin
      w = sel ? q1.pop_front() : q0.pop_front();
      check({tag, "_valid"}, sel ? valid1 : valid0, 1);
      check({tag, "_data"},  sel ? data1  : data0,  w.data);
      check({tag, "_perr"},  sel ? perr1  : perr0,  w.perr);
      check({tag, "_ferr"},  sel ? ferr1  : ferr0,  w.ferr);
      if (sel == 0) ready0 = 1'b1;
      else          ready1 = 1'b1;
      @(negedge clk);
    end
    ready0 = 1'b0;
    ready1 = 1'b0;
    check({tag, "_empty_valid"}, sel ? valid1 : valid0, 0);
    check({tag, "_empty_data"},  sel ? data1  : data0,  0);
    check({tag, "_empty_level"}, sel ? level1 : level0, 0);
  endtask

  initial begin
    int rises0;
    int n;
    int gap;
    logic stop;
    reset  = 1'b1;
    rxd0   = 1'b1;
    rxd1   = 1'b1;
    ready0 = 1'b0;
    ready1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", valid0, 0);
    check("rst_data",  data0,  0);
    check("rst_level", level0, 0);
    check("rst_busy",  busy0,  0);
    check("rst_ovr",   ovr0,   0);
    check("rst_flags", {perr1, ferr1, valid1, busy1}, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    send_frame(0, 8'hA5, -1, 1'b1);
    hold(0, 1'b1, 10);
    drain(0, "a5");

    send_frame(1, 8'h03, 1, 1'b1);
    send_frame(1, 8'h03, 0, 1'b1);
    hold(1, 1'b1, CPB);
    check("par_err_first", q1[0].perr, 1);
    drain(1, "par");

    send_frame(0, 8'h55, -1, 1'b0);
    hold(0, 1'b0, 20 * CPB);
    check("ferr_busy_low", busy0, 0);
    check("ferr_one_word", level0, 1);
    hold(0, 1'b1, 2 * CPB);
    send_frame(0, 8'h12, -1, 1'b1);
    hold(0, 1'b1, CPB);
    drain(0, "ferr");

    rises0 = busy_rises;
    hold(0, 1'b0, 20);
    hold(0, 1'b1, 4 * CPB);
    check("glitch_busy_pulse", busy_rises - rises0, 1);
    check("glitch_busy", busy0, 0);
    check("glitch_level", level0, 0);

    for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), -1, 1'b1);
    hold(0, 1'b1, CPB);
    check("ovr_level", level0, 4);
    check("ovr_pulses", ovr_seen0, exp_ovr0);
    check("ovr_once", exp_ovr0, 1);
    drain(0, "ovr");

    send_frame(0, 8'h33, -1, 1'b1);
    hold(0, 1'b1, CPB);
    check("pre_rst_level", level0, 1);
    hold(0, 1'b0, CPB);
    hold(0, 1'b1, CPB);
    hold(0, 1'b0, CPB);
    hold(0, 1'b1, CPB);
    hold(0, 1'b1, 40);
    check("mid_busy", busy0, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q0.delete();
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_level", level0, 0);
    check("mid_rst_valid", valid0, 0);
    hold(0, 1'b1, 2 * CPB);
    send_frame(0, 8'h5A, -1, 1'b1);
    hold(0, 1'b1, CPB);
    drain(0, "after_rst");

    for (int b = 0; b < 4; b++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        stop = ($urandom % 4) != 0;
        send_frame(0, 8'($urandom), -1, stop);
        gap = $urandom_range(stop ? 0 : CPB, 2 * CPB);
        hold(0, 1'b1, gap);
      end
      hold(0, 1'b1, CPB);
      drain(0, "rnd0");
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        send_frame(1, 8'($urandom), int'($urandom % 2), 1'b1);
        hold(1, 1'b1, $urandom_range(0, CPB));
      end
      hold(1, 1'b1, CPB);
      drain(1, "rnd1");
    end

    check("final_ovr0", ovr_seen0, exp_ovr0);
    check("final_ovr1", ovr_seen1, exp_ovr1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
